mdu_sequencer: RTL and testbench

- Multi-cycle controller that executes unsigned MUL (low word), DIVU and REMU by sequencing the shared 32-bit single-cycle ALU (ADD/SUB/SLT ops) one step per clock.
- Sits beside the ALU in the execute stage.
- The core issues one request and receives one result pulse.
- The ALU remains purely combinational; this block drives its A/B/control inputs and samples its result in the same cycle.

---
 rtl/mdu_sequencer.sv | 151 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Runs unsigned MUL/DIVU/REMU by stepping the shared combinational ALU once per clock.
// 32 cycles per MUL, 64 per divide; no backpressure, so the one-cycle OutValid must be taken.
module mdu_sequencer #(
  parameter int         XLEN    = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0011,
  parameter logic [3:0] ALU_SLT = 4'b0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [1:0]      MdOp,
  input  logic [XLEN-1:0] OpA,
  input  logic [XLEN-1:0] OpB,
  input  logic            Flush,
  output logic            Busy,
  output logic            OutValid,
  output logic [XLEN-1:0] Result,
  output logic [XLEN-1:0] AluA,
  output logic [XLEN-1:0] AluB,
  output logic [3:0]      AluCtrl,
  input  logic [XLEN-1:0] AluResult
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_CMP, S_DIV_SUB, S_DONE} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  state_t          state;
  logic [1:0]      op;
  logic [XLEN-1:0] acc;  // product P in MUL, remainder R in divide
  logic [XLEN-1:0] sh;   // multiplicand M in MUL, quotient Q in divide
  logic [XLEN-1:0] nd;   // multiplier N in MUL, divisor D in divide
  logic [4:0]      cnt;
  logic            lt;

  logic [XLEN-1:0] rs;
  logic [XLEN-1:0] p_next;
  logic [XLEN-1:0] r_next;
  logic [XLEN-1:0] q_next;

  assign rs     = {acc[XLEN-2:0], sh[XLEN-1]};
  assign p_next = nd[0] ? AluResult : acc;
  assign r_next = lt ? acc : AluResult;
  assign q_next = {sh[XLEN-1:1], ~lt};

  assign Busy    = (state != S_IDLE);
  assign InReady = (state == S_IDLE);

  always_comb begin
    AluCtrl = ALU_ADD;
    AluA    = '0;
    AluB    = '0;
    case (state)
      S_MUL: begin
        AluA = acc;
        AluB = sh;
      end
      S_DIV_CMP: begin
        AluCtrl = ALU_SLT;
        AluA    = rs;
        AluB    = nd;
      end
      S_DIV_SUB: begin
        AluCtrl = ALU_SUB;
        AluA    = acc;
        AluB    = nd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op       <= '0;
      acc      <= '0;
      sh       <= '0;
      nd       <= '0;
      cnt      <= '0;
      lt       <= 1'b0;
      OutValid <= 1'b0;
      Result   <= '0;
    end else begin
      OutValid <= 1'b0;
      if (Flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (InValid) begin
              op  <= MdOp;
              acc <= '0;
              sh  <= OpA;
              nd  <= OpB;
              cnt <= '0;
              lt  <= 1'b0;
              if (MdOp == OP_MUL) begin
                state <= S_MUL;
              end else if ((MdOp == OP_DIVU || MdOp == OP_REMU) && OpB != '0) begin
                state <= S_DIV_CMP;
              end else begin
                // Divide-by-zero and the reserved op complete without touching the ALU.
                state    <= S_DONE;
                OutValid <= 1'b1;
                if (MdOp == OP_DIVU)      Result <= '1;
                else if (MdOp == OP_REMU) Result <= OpA;
                else                      Result <= '0;
              end
            end
          end
          S_MUL: begin
            acc <= p_next;
            sh  <= sh << 1;
            nd  <= nd >> 1;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state    <= S_DONE;
              OutValid <= 1'b1;
              Result   <= p_next;
            end
          end
          S_DIV_CMP: begin
            // A set carry means the shifted remainder already exceeds any 32-bit divisor.
            acc   <= rs;
            sh    <= sh << 1;
            lt    <= ~acc[XLEN-1] & AluResult[0];
            state <= S_DIV_SUB;
          end
          S_DIV_SUB: begin
            acc <= r_next;
            sh  <= q_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state    <= S_DONE;
              OutValid <= 1'b1;
              Result   <= (op == OP_DIVU) ? q_next : r_next;
            end else begin
              state <= S_DIV_CMP;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboarded directed bench for mdu_sequencer with a behavioural ALU alongside.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [1:0]  MdOp = '0;
  logic [31:0] OpA = '0;
  logic [31:0] OpB = '0;
  logic        Flush = 1'b0;
  logic        Busy;
  logic        OutValid;
  logic [31:0] Result;
  logic [31:0] AluA;
  logic [31:0] AluB;
  logic [3:0]  AluCtrl;
  logic [31:0] AluResult;

  mdu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady), .MdOp(MdOp),
    .OpA(OpA), .OpB(OpB), .Flush(Flush), .Busy(Busy), .OutValid(OutValid),
    .Result(Result), .AluA(AluA), .AluB(AluB), .AluCtrl(AluCtrl), .AluResult(AluResult)
  );

  always #5 clk = ~clk;

  always_comb begin
    AluResult = '0;
    case (AluCtrl)
      4'b0010: AluResult = AluA + AluB;
      4'b0011: AluResult = AluA - AluB;
      4'b0100: AluResult = {31'd0, AluA < AluB};
      default: AluResult = '0;
    endcase
  end

  typedef struct {
    logic [31:0] res;
    int          lo;
    int          hi;
    int          k;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   pushed = 0;
  int   seen   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every OutValid pops one expectation and checks value and latency.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   lat;
    if (rst_n && OutValid) begin
      seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_outvalid: got Result %h with no pending request", Result);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, Result, e.res);
        lat = cyc - e.k;
        tests++;
        if (lat < e.lo || lat > e.hi) begin
          fails++;
          $display("FAIL %s_latency: got %0d edges expected %0d..%0d", e.name, lat, e.lo, e.hi);
        end
      end
    end
  end

  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lo,
                       input int hi, input bit track);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!InReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!InReady) check({name, "_ready_timeout"}, {31'd0, InReady}, 32'd1);
    InValid = 1'b1;
    MdOp    = op;
    OpA     = a;
    OpB     = b;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    if (track) begin
      e.res = res; e.lo = lo; e.hi = hi; e.k = cyc; e.name = name;
      exp_q.push_back(e);
      pushed++;
    end
  endtask

  // Counts busy negedges following an accepted request until InReady returns.
  task automatic wait_idle(input string name, input int expected);
    int n = 0;
    @(negedge clk);
    while (!InReady && n < 300) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, n, expected);
  endtask

  initial begin
    int w;
    #1;
    check("rst_outvalid", {31'd0, OutValid}, 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_inready", {31'd0, InReady}, 32'd1);
    check("rst_aluctrl", {28'd0, AluCtrl}, 32'd2);
    check("rst_alua", AluA, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 32, 32, 1'b1);
    wait_idle("mul_7x6", 33);
    issue("mul_ffff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 32, 1'b1);
    issue("mul_wrap", 2'b00, 32'h00010000, 32'h00010000, 32'h0, 32, 32, 1'b1);
    issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 64, 64, 1'b1);
    wait_idle("divu_100_7", 65);
    issue("remu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 64, 64, 1'b1);
    issue("divu_carry", 2'b01, 32'hFFFFFFFF, 32'h80000001, 32'd1, 64, 64, 1'b1);
    issue("remu_carry", 2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 64, 64, 1'b1);
    issue("divu_by0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 1, 1'b1);
    issue("remu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 0, 1, 1'b1);
    issue("op_rsvd", 2'b11, 32'd9, 32'd3, 32'd0, 0, 1, 1'b1);
    issue("remu_by0_b", 2'b10, 32'h1234, 32'd0, 32'h1234, 0, 1, 1'b1);

    // Flush a divide partway through; Result must keep 0x1234.
    issue("div_flushed", 2'b01, 32'd1000, 32'd3, 32'd0, 0, 0, 1'b0);
    repeat (39) @(posedge clk);
    @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_inready", {31'd0, InReady}, 32'd1);
    check("flush_result_held", Result, 32'h1234);
    repeat (40) @(negedge clk);
    check("flush_result_later", Result, 32'h1234);

    // Flush together with a request in IDLE: request must not be taken.
    InValid = 1'b1; MdOp = 2'b00; OpA = 32'd2; OpB = 32'd2; Flush = 1'b1;
    @(negedge clk);
    InValid = 1'b0; Flush = 1'b0;
    check("flush_idle_busy", {31'd0, Busy}, 32'd0);

    issue("mul_3x4", 2'b00, 32'd3, 32'd4, 32'd12, 32, 32, 1'b1);
    wait_idle("mul_3x4", 33);

    // Asynchronous reset in the middle of a multiply.
    issue("mul_reset", 2'b00, 32'd9, 32'd9, 32'd0, 0, 0, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outvalid", {31'd0, OutValid}, 32'd0);
    check("arst_result", Result, 32'd0);
    check("arst_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Requests presented while busy must be ignored.
    issue("mul_5x5", 2'b00, 32'd5, 32'd5, 32'd25, 32, 32, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      InValid = (i % 2 == 0);
      MdOp    = 2'(i % 3);
      OpA     = 32'(i + 11);
      OpB     = 32'(i + 1);
    end
    @(negedge clk);
    InValid = 1'b0;
    issue("divu_77_8", 2'b01, 32'd77, 32'd8, 32'd9, 64, 64, 1'b1);

    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    check("outvalid_count", seen, pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
